// File: rtl/updown_sel_ctrl_pkg.sv
// rtl/updown_sel_ctrl_pkg.sv - mode codes and widths shared by the up/down select controller
package updown_ctrl_pkg;

    localparam int MODE_W = 2;
    localparam int BTN_N  = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10
    } mode_e;

    // Bit positions inside btn_level / press vectors: {hold,down,up}
    localparam int BTN_UP   = 0;
    localparam int BTN_DOWN = 1;
    localparam int BTN_HOLD = 2;

endpackage

// File: rtl/updown_sel_ctrl_if.sv
// rtl/updown_sel_ctrl_if.sv - button inputs and counter-command outputs; count_val only with UPDOWN_AUTO_REVERSE_EN
interface updown_sel_ctrl_if;
    import updown_ctrl_pkg::*;

    logic                  btn_up;
    logic                  btn_down;
    logic                  btn_hold;
`ifdef UPDOWN_AUTO_REVERSE_EN
    logic [3:0]            count_val;
`endif
    logic [MODE_W-1:0]     sel;
    logic [MODE_W-1:0]     mode;
    logic                  tick;
    logic [BTN_N-1:0]      btn_level;

    // Controller side
    modport slave (
`ifdef UPDOWN_AUTO_REVERSE_EN
        input  count_val,
`endif
        input  btn_up,
        input  btn_down,
        input  btn_hold,
        output sel,
        output mode,
        output tick,
        output btn_level
    );

    // Button/counter side
    modport master (
`ifdef UPDOWN_AUTO_REVERSE_EN
        output count_val,
`endif
        output btn_up,
        output btn_down,
        output btn_hold,
        input  sel,
        input  mode,
        input  tick,
        input  btn_level
    );

endinterface

// File: rtl/updown_sel_ctrl_debounce.sv
// rtl/updown_sel_ctrl_debounce.sv - 2-flop synchronizer, counter debounce and rising-edge press detect
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int            CW      = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          stable_q;
    logic          stable_d_q;
    logic [CW-1:0] cnt_q;
    logic          synced;

    assign synced = sync_q[1];

    // Bring the raw asynchronous button into the clock domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

    // Accept a new level only after it has differed for DEB_CYCLES consecutive cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else if (synced == stable_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_q <= synced;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Delayed copy of the debounced level for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_d_q <= 1'b0;
        end else begin
            stable_d_q <= stable_q;
        end
    end

    assign level = stable_q;
    assign press = stable_q & ~stable_d_q;

endmodule

// File: rtl/updown_sel_ctrl.sv
// rtl/updown_sel_ctrl.sv - mode FSM, prescaler and rate-limited sel for the up/down counter; option UPDOWN_AUTO_REVERSE_EN
module updown_sel_ctrl
    import updown_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int PRESCALE   = 4
) (
    input logic              clk,
    input logic              rst,
    updown_sel_ctrl_if.slave bus
);

    localparam int            PW      = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [BTN_N-1:0] level;
    logic [BTN_N-1:0] press;
    logic [PW-1:0]    pre_q;
    logic             tick;
    mode_e            mode_q;
    mode_e            mode_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.btn_up),
        .level   (level[BTN_UP]),
        .press   (press[BTN_UP])
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.btn_down),
        .level   (level[BTN_DOWN]),
        .press   (press[BTN_DOWN])
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_hold (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.btn_hold),
        .level   (level[BTN_HOLD]),
        .press   (press[BTN_HOLD])
    );

    // Free-running prescaler; mode changes never restart it so the step rate stays steady
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
        end else if (pre_q == PRE_MAX) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    assign tick = (pre_q == PRE_MAX);

    // Mode state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= MODE_HOLD;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Next mode: hold press dominates, up+down together cancel, auto-reverse only when no button event
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_HOLD, MODE_UP, MODE_DOWN: begin
                if (press[BTN_HOLD]) begin
                    mode_d = MODE_HOLD;
                end else if (press[BTN_UP] && !press[BTN_DOWN]) begin
                    mode_d = MODE_UP;
                end else if (press[BTN_DOWN] && !press[BTN_UP]) begin
                    mode_d = MODE_DOWN;
`ifdef UPDOWN_AUTO_REVERSE_EN
                end else if (!(|press) && tick && (mode_q == MODE_UP) && (bus.count_val == 4'hE)) begin
                    mode_d = MODE_DOWN;
                end else if (!(|press) && tick && (mode_q == MODE_DOWN) && (bus.count_val == 4'h1)) begin
                    mode_d = MODE_UP;
`endif
                end
            end
            default: mode_d = MODE_HOLD;
        endcase
    end

    assign bus.mode      = mode_q;
    assign bus.tick      = tick;
    assign bus.sel       = tick ? mode_q : MODE_HOLD;
    assign bus.btn_level = level;

endmodule

// File: tb/tb_updown_sel_ctrl.sv
// tb/tb_updown_sel_ctrl.sv - scoreboard bench: DEB_CYCLES=4 with PRESCALE=4 (dut_a) and PRESCALE=1 (dut_b)
module tb_updown_sel_ctrl;

    typedef struct {
        string      name;
        int         which;
        int         tc;
        logic [1:0] mode;
        logic [1:0] sel;
        logic       tick;
        logic [2:0] lvl;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t q[$];

    updown_sel_ctrl_if bus_a();
    updown_sel_ctrl_if bus_b();

    updown_sel_ctrl #(.DEB_CYCLES(4), .PRESCALE(4)) dut_a (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_a)
    );

    updown_sel_ctrl #(.DEB_CYCLES(4), .PRESCALE(1)) dut_b (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; dut_a prescaler equals cyc % 4
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic push(input string name, input int which, input int tc,
                        input logic [1:0] m, input logic [2:0] lvl, input bit in_rst);
        exp_t e;
        e.name  = name;
        e.which = which;
        e.tc    = tc;
        e.mode  = m;
        e.lvl   = lvl;
        e.tick  = (which == 1) ? 1'b1 : (in_rst ? 1'b0 : ((tc % 4) == 3));
        e.sel   = e.tick ? m : 2'b00;
        q.push_back(e);
    endtask

    task automatic both(input string name, input int tc, input logic [1:0] m, input logic [2:0] lvl);
        push(name, 0, tc, m, lvl, 1'b0);
        push(name, 1, tc, m, lvl, 1'b0);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input logic u, input logic d, input logic h);
        bus_a.btn_up = u; bus_a.btn_down = d; bus_a.btn_hold = h;
        bus_b.btn_up = u; bus_b.btn_down = d; bus_b.btn_hold = h;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (q.size() != 0 && n < bound) begin
            step(1);
            n++;
        end
        if (q.size() != 0) begin
            $display("FAIL drain_timeout: %0d expectations pending, required 0", q.size());
            checks++;
            errors++;
            q.delete();
        end
    endtask

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        exp_t       e;
        logic [1:0] am;
        logic [1:0] as;
        logic       at;
        logic [2:0] al;
        while (q.size() > 0 && q[0].tc <= cyc) begin
            e  = q.pop_front();
            am = (e.which == 1) ? bus_b.mode      : bus_a.mode;
            as = (e.which == 1) ? bus_b.sel       : bus_a.sel;
            at = (e.which == 1) ? bus_b.tick      : bus_a.tick;
            al = (e.which == 1) ? bus_b.btn_level : bus_a.btn_level;
            checks++;
            if (e.tc != cyc || am !== e.mode || as !== e.sel || at !== e.tick || al !== e.lvl) begin
                errors++;
                $display("FAIL %s dut%0d cyc %0d: got mode=%b sel=%b tick=%b lvl=%b, required cyc %0d mode=%b sel=%b tick=%b lvl=%b",
                         e.name, e.which, cyc, am, as, at, al, e.tc, e.mode, e.sel, e.tick, e.lvl);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int k;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        set_btns(1'b0, 1'b0, 1'b0);
`ifdef UPDOWN_AUTO_REVERSE_EN
        bus_a.count_val = 4'h5;
        bus_b.count_val = 4'h5;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        both("reset_state", cyc, 2'b00, 3'b000);
        drain(50);

        // Up press latency, then sel only on ticks
        step(2);
        t = cyc;
        set_btns(1'b1, 1'b0, 1'b0);
        both("up_lvl_early", t + 5, 2'b00, 3'b000);
        both("up_lvl",       t + 6, 2'b00, 3'b001);
        both("up_mode",      t + 7, 2'b01, 3'b001);
        for (int i = 8; i < 12; i++) both("up_sel", t + i, 2'b01, 3'b001);
        drain(50);
        t = cyc;
        set_btns(1'b0, 1'b0, 1'b0);
        both("up_release", t + 8, 2'b01, 3'b000);
        drain(50);

        // Down glitch of 3 cycles ignored, then a real press
        t = cyc;
        set_btns(1'b0, 1'b1, 1'b0);
        for (int i = 6; i < 9; i++) both("down_glitch", t + i, 2'b01, 3'b000);
        step(3);
        set_btns(1'b0, 1'b0, 1'b0);
        drain(50);
        t = cyc;
        set_btns(1'b0, 1'b1, 1'b0);
        both("down_lvl",  t + 6, 2'b01, 3'b010);
        both("down_mode", t + 7, 2'b10, 3'b010);
        drain(50);
        t = cyc;
        set_btns(1'b0, 1'b0, 1'b0);
        both("down_release", t + 8, 2'b10, 3'b000);
        drain(50);

        // Up+down together: no change; with hold: hold wins
        t = cyc;
        set_btns(1'b1, 1'b1, 1'b0);
        both("updown_same",  t + 7,  2'b10, 3'b011);
        both("updown_same2", t + 10, 2'b10, 3'b011);
        drain(50);
        t = cyc;
        set_btns(1'b0, 1'b0, 1'b0);
        both("updown_release", t + 8, 2'b10, 3'b000);
        drain(50);
        t = cyc;
        set_btns(1'b1, 1'b1, 1'b1);
        both("hold_lvl",  t + 6, 2'b10, 3'b111);
        both("hold_wins", t + 7, 2'b00, 3'b111);
        drain(50);
        t = cyc;
        set_btns(1'b0, 1'b0, 1'b0);
        both("all_release", t + 8, 2'b00, 3'b000);
        drain(50);

        // PRESCALE=1 sel every cycle; a long hold of up is a single event
        t = cyc;
        set_btns(1'b1, 1'b0, 1'b0);
        for (int i = 7; i < 11; i++) both("pre1_up", t + i, 2'b01, 3'b001);
        drain(50);
        t = cyc;
        set_btns(1'b1, 1'b0, 1'b1);
        both("held_hold",   t + 7,   2'b00, 3'b101);
        both("held_up_50",  t + 50,  2'b00, 3'b001);
        both("held_up_100", t + 100, 2'b00, 3'b001);
        step(6);
        set_btns(1'b1, 1'b0, 1'b0);
        drain(300);

        // Asynchronous reset with mode=UP, then button held through release
        t = cyc;
        set_btns(1'b0, 1'b0, 1'b0);
        both("pre_rst_release", t + 8, 2'b00, 3'b000);
        drain(50);
        t = cyc;
        set_btns(1'b1, 1'b0, 1'b0);
        both("pre_rst_up", t + 7, 2'b01, 3'b001);
        drain(50);
        t = cyc;
        rst_n = 1'b0;
        push("async_rst", 0, t, 2'b00, 3'b000, 1'b1);
        push("async_rst", 1, t, 2'b00, 3'b000, 1'b1);
        drain(50);
        step(2);
        rst_n = 1'b1;
        t = cyc;
        both("rst_btn_lvl",     t + 6, 2'b00, 3'b001);
        both("rst_fresh_press", t + 7, 2'b01, 3'b001);
        drain(50);

`ifdef UPDOWN_AUTO_REVERSE_EN
        // Auto-reverse at UP/E and DOWN/1 on tick edges (edges k with k % 4 == 0)
        t = cyc;
        bus_a.count_val = 4'hE;
        k = t + 1;
        while ((k % 4) != 0) k++;
        push("ar_before_down", 0, k - 1, 2'b01, 3'b001, 1'b0);
        push("ar_to_down",     0, k,     2'b10, 3'b001, 1'b0);
        drain(50);
        t = cyc;
        bus_a.count_val = 4'h1;
        k = t + 1;
        while ((k % 4) != 0) k++;
        push("ar_to_up", 0, k, 2'b01, 3'b001, 1'b0);
        drain(50);
        bus_a.count_val = 4'h5;
        while ((cyc % 4) != 1) step(1);
        t = cyc;
        bus_a.btn_hold = 1'b1;
        push("ar_pre_hold", 0, t + 6, 2'b01, 3'b101, 1'b0);
        push("ar_vs_hold",  0, t + 7, 2'b00, 3'b101, 1'b0);
        step(4);
        bus_a.count_val = 4'hE;
        drain(50);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
